pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Upstream control stage of the SoC clock generator PLL, clocked by the free-running board refclk (125 MHz).
//  Drives the PLL's active-high rst and watches its async locked output.
//  Releases the SoC reset only after lock has been stable for a programmable time.
//  Re-runs the PLL reset on lock loss, lock timeout or a software request, and keeps saturating status counters.
// PARAMETERS
//  RST_PULSE_CYCLES     16      PLL rst high time in i_clk cycles (>=1)
//  LOCK_STABLE_CYCLES   1024    consecutive synced-locked cycles required before SoC reset release (>=1)
//  LOCK_TIMEOUT_CYCLES  125000  max cycles waiting for lock before PLL reset is re-issued (>=2)
//  Internal counter width = $clog2(max of the three)+1 (localparam, not user-set)
// PORTS
//  i_clk            in   1  board refclk, also feeds PLL refclk
//  i_nrst           in   1  async active-low reset
//  i_locked         in   1  PLL locked, asynchronous to i_clk
//  i_soft_rst       in   1  sync one-cycle request to restart PLL + SoC reset sequence
//  o_pll_rst        out  1  to PLL rst, active high
//  o_sys_nrst       out  1  SoC reset, active low; re-synchronised in the PLL output domain by the consumer
//  o_state          out  2  current FSM state (encoding below)
//  o_lock_lost_cnt  out  8  count of lock losses while in RUN, saturates at 255
//  o_timeout_cnt    out  8  count of WAIT_LOCK timeouts, saturates at 255
// BEHAVIOUR
//  Reset values (i_nrst low, async)
//   - o_pll_rst=1, o_sys_nrst=0, state=PLL_RST, cnt=0
//   - both status counters=0, sync flops=0
//  Synchroniser: i_locked passes through 2 flops -> locked_s, 2-edge latency.
//  All outputs are registered; no combinational path from any input to any output.
//  FSM (o_state): PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3
//   - PLL_RST: o_pll_rst=1, o_sys_nrst=0.
//     cnt==RST_PULSE_CYCLES-1 -> WAIT_LOCK, cnt=0, o_pll_rst=0 on that edge; else cnt++.
//   - WAIT_LOCK: locked_s=1 -> STABLE, cnt=0.
//     Else cnt==LOCK_TIMEOUT_CYCLES-1 -> PLL_RST, cnt=0, o_timeout_cnt++, o_pll_rst=1; else cnt++.
//   - STABLE: locked_s=0 -> WAIT_LOCK, cnt=0 (glitch restarts qualification, no counter change).
//     Else cnt==LOCK_STABLE_CYCLES-1 -> RUN, o_sys_nrst=1 on that edge; else cnt++.
//   - RUN: locked_s=0 -> PLL_RST, cnt=0, o_sys_nrst=0, o_pll_rst=1, o_lock_lost_cnt++.
//  i_soft_rst=1 in any state: -> PLL_RST, cnt=0, o_pll_rst=1, o_sys_nrst=0; no counter increments.
//  Priority: i_nrst > i_soft_rst > lock loss / timeout > normal count.
//  Lock loss coinciding with i_soft_rst: o_lock_lost_cnt unchanged.
//  Timing from PLL_RST entry with locked already high
//   - o_pll_rst high for exactly RST_PULSE_CYCLES edges.
//   - After i_locked first sampled high at edge N (lock held), o_sys_nrst rises after edge N+2+LOCK_STABLE_CYCLES.
//  o_sys_nrst falls one edge after locked_s falls in RUN, i.e. <=3 edges after i_locked falls.
//  Status counters hold at 255 and never wrap.
//  Async reset mid-sequence aborts immediately to reset values; the sequence restarts after release.
// TESTING (bench params: RST_PULSE=4, LOCK_STABLE=8, LOCK_TIMEOUT=32)
//  1 Release i_nrst, PLL model asserts locked 10 cycles after rst falls
//    -> o_pll_rst high 4 edges; o_sys_nrst=1 exactly 10 edges after locked sampled; o_state=3.
//  2 Hold i_locked=0 -> o_pll_rst re-pulses every 4+32 cycles; o_timeout_cnt counts 1,2,3.
//    Force 300 timeouts -> counter stays 255.
//  3 In RUN, drop i_locked for 1 cycle -> o_sys_nrst=0 within 3 edges; o_lock_lost_cnt=1.
//    Full re-sequence follows; o_sys_nrst returns high.
//  4 In STABLE at cnt=5, glitch i_locked low 1 cycle
//    -> state goes to WAIT_LOCK with no counter change; qualification restarts from 0 (8 full cycles).
//  5 i_soft_rst pulse in RUN, and again in WAIT_LOCK
//    -> PLL_RST next edge, o_pll_rst=1, o_sys_nrst=0, both counters unchanged.
//  6 Assert i_nrst low mid-STABLE and mid-PLL_RST
//    -> all outputs take reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if
//   Groups the PLL-facing and SoC-facing control/status signals of the PLL
//   reset sequencer. Clock and reset stay as plain ports on the modules.
//   i_locked         PLL locked, asynchronous to the sequencer clock
//   i_soft_rst       one-cycle synchronous restart request
//   o_pll_rst        PLL reset, active high
//   o_sys_nrst       SoC reset, active low
//   o_state          current sequencer state
//   o_lock_lost_cnt  saturating count of lock losses while running
//   o_timeout_cnt    saturating count of lock-wait timeouts
//   master: the sequencer side; slave: the PLL / SoC / software side.
interface pll_reset_sequencer_if;
    logic       i_locked;
    logic       i_soft_rst;
    logic       o_pll_rst;
    logic       o_sys_nrst;
    logic [1:0] o_state;
    logic [7:0] o_lock_lost_cnt;
    logic [7:0] o_timeout_cnt;

    modport master (
        input  i_locked,
        input  i_soft_rst,
        output o_pll_rst,
        output o_sys_nrst,
        output o_state,
        output o_lock_lost_cnt,
        output o_timeout_cnt
    );

    modport slave (
        output i_locked,
        output i_soft_rst,
        input  o_pll_rst,
        input  o_sys_nrst,
        input  o_state,
        input  o_lock_lost_cnt,
        input  o_timeout_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Drives the PLL reset, qualifies PLL lock for a programmable time and only
//   then releases the SoC reset. Lock loss, lock timeout or a software request
//   re-run the whole sequence. Keeps saturating lock-loss / timeout counters.
// Ports
//   i_clk   board refclk (also the PLL reference)
//   i_nrst  asynchronous active-low reset
//   bus     control/status bundle (see pll_reset_sequencer_if), master side
//
// state     | meaning
// PLL_RST   | PLL held in reset for RST_PULSE_CYCLES, SoC held in reset
// WAIT_LOCK | PLL released, waiting for synced lock (bounded by timeout)
// STABLE    | lock seen, counting consecutive locked cycles
// RUN       | SoC reset released, watching for lock loss
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 125000
) (
    input  logic                     i_clk,
    input  logic                     i_nrst,
    pll_reset_sequencer_if.master    bus
);

    localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    lock_sync;
    logic          locked_s;
    logic          pll_rst;
    logic          sys_nrst;
    logic [7:0]    lock_lost_cnt;
    logic [7:0]    timeout_cnt;

    assign locked_s = lock_sync[1];

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            lock_sync     <= 2'b00;
            state         <= PLL_RST;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            sys_nrst      <= 1'b0;
            lock_lost_cnt <= 8'd0;
            timeout_cnt   <= 8'd0;
        end else begin
            // i_locked is asynchronous: two-flop synchroniser before any use.
            lock_sync <= {lock_sync[0], bus.i_locked};

            if (bus.i_soft_rst) begin
                // Software restart outranks lock loss, so no counter moves here.
                state    <= PLL_RST;
                cnt      <= '0;
                pll_rst  <= 1'b1;
                sys_nrst <= 1'b0;
            end else begin
                unique case (state)
                    PLL_RST: begin
                        if (cnt == RST_LAST) begin
                            state   <= WAIT_LOCK;
                            cnt     <= '0;
                            pll_rst <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    WAIT_LOCK: begin
                        if (locked_s) begin
                            state <= STABLE;
                            cnt   <= '0;
                        end else if (cnt == TIMEOUT_LAST) begin
                            state   <= PLL_RST;
                            cnt     <= '0;
                            pll_rst <= 1'b1;
                            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    STABLE: begin
                        // A lock glitch restarts qualification from zero.
                        if (!locked_s) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == STABLE_LAST) begin
                            state    <= RUN;
                            cnt      <= '0;
                            sys_nrst <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    RUN: begin
                        if (!locked_s) begin
                            state    <= PLL_RST;
                            cnt      <= '0;
                            pll_rst  <= 1'b1;
                            sys_nrst <= 1'b0;
                            if (lock_lost_cnt != 8'hFF) lock_lost_cnt <= lock_lost_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state    <= PLL_RST;
                        cnt      <= '0;
                        pll_rst  <= 1'b1;
                        sys_nrst <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_pll_rst       = pll_rst;
    assign bus.o_sys_nrst      = sys_nrst;
    assign bus.o_state         = state;
    assign bus.o_lock_lost_cnt = lock_lost_cnt;
    assign bus.o_timeout_cnt   = timeout_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Directed bench for pll_reset_sequencer with RST_PULSE=4, LOCK_STABLE=8,
//   LOCK_TIMEOUT=32. Inputs change and outputs are sampled on the falling
//   clock edge; "En" in comments is the n-th rising edge since reset release.
module tb_pll_reset_sequencer;

    logic clk;
    logic nrst;
    int   total = 0;
    int   bad   = 0;

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32)
    ) dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic chk_out(input string tag, input int st, input int prst, input int snrst,
                           input int lost, input int tmo);
        chk({tag, ".state"},    32'(bus.o_state),         32'(st));
        chk({tag, ".pll_rst"},  32'(bus.o_pll_rst),       32'(prst));
        chk({tag, ".sys_nrst"}, 32'(bus.o_sys_nrst),      32'(snrst));
        chk({tag, ".lost"},     32'(bus.o_lock_lost_cnt), 32'(lost));
        chk({tag, ".timeout"},  32'(bus.o_timeout_cnt),   32'(tmo));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        nrst           = 1'b1;
        bus.i_locked   = 1'b0;
        bus.i_soft_rst = 1'b0;
        #1 nrst = 1'b0;
        #2 chk_out("reset_async", 0, 1, 0, 0, 0);
        cyc(2);
        chk_out("reset_held", 0, 1, 0, 0, 0);

        // Test 1: power-up sequence, PLL locks 10 cycles after its reset falls
        nrst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc(1);
            chk($sformatf("t1.pll_rst_high_E%0d", i), 32'(bus.o_pll_rst), 32'd1);
        end
        cyc(1);                                         // E4
        chk("t1.pll_rst_fall", 32'(bus.o_pll_rst), 32'd0);
        chk("t1.wait_lock",    32'(bus.o_state),   32'd1);
        cyc(9);                                         // E13
        bus.i_locked = 1'b1;                            // sampled at E14
        cyc(10);                                        // E23
        chk("t1.stable_before", 32'(bus.o_state),    32'd2);
        chk("t1.sys_low",       32'(bus.o_sys_nrst), 32'd0);
        cyc(1);                                         // E24 = 14 + 10
        chk_out("t1.run", 3, 0, 1, 0, 0);

        // Test 3: one-cycle lock drop in RUN
        bus.i_locked = 1'b0;
        cyc(1);                                         // E25
        bus.i_locked = 1'b1;
        cyc(1);                                         // E26
        chk("t3.sys_still_high", 32'(bus.o_sys_nrst), 32'd1);
        cyc(1);                                         // E27
        chk_out("t3.lock_lost", 0, 1, 0, 1, 0);
        cyc(12);                                        // E39
        chk("t3.reseq_stable", 32'(bus.o_state), 32'd2);
        cyc(1);                                         // E40
        chk_out("t3.reseq_run", 3, 0, 1, 1, 0);

        // Test 5a: soft reset in RUN
        bus.i_soft_rst = 1'b1;
        cyc(1);                                         // E41
        bus.i_soft_rst = 1'b0;
        chk_out("t5.soft_run", 0, 1, 0, 1, 0);

        // Test 4: lock glitch while qualifying (cnt=5 after E51)
        cyc(10);                                        // E51
        chk("t4.in_stable", 32'(bus.o_state), 32'd2);
        bus.i_locked = 1'b0;
        cyc(1);                                         // E52
        bus.i_locked = 1'b1;
        cyc(1);                                         // E53
        chk("t4.stable_late", 32'(bus.o_state), 32'd2);
        cyc(1);                                         // E54
        chk_out("t4.glitch", 1, 0, 0, 1, 0);
        cyc(8);                                         // E62
        chk("t4.requal_stable", 32'(bus.o_state), 32'd2);
        cyc(1);                                         // E63
        chk_out("t4.requal_run", 3, 0, 1, 1, 0);

        // Lock lost for good; then soft reset while waiting for lock
        bus.i_locked = 1'b0;
        cyc(3);                                         // E66
        chk_out("t2.lost2", 0, 1, 0, 2, 0);
        cyc(4);                                         // E70
        chk("t5.in_wait", 32'(bus.o_state), 32'd1);
        bus.i_soft_rst = 1'b1;
        cyc(1);                                         // E71
        bus.i_soft_rst = 1'b0;
        chk_out("t5.soft_wait", 0, 1, 0, 2, 0);

        // Test 2: timeouts every 4 + 32 cycles
        cyc(4);                                         // E75
        chk("t2.wait_entry", 32'(bus.o_state), 32'd1);
        cyc(31);                                        // E106
        chk_out("t2.pre_timeout", 1, 0, 0, 2, 0);
        cyc(1);                                         // E107
        chk_out("t2.timeout1", 0, 1, 0, 2, 1);
        cyc(3);                                         // E110
        chk("t2.pulse_last", 32'(bus.o_pll_rst), 32'd1);
        cyc(1);                                         // E111
        chk("t2.pulse_end", 32'(bus.o_pll_rst), 32'd0);
        cyc(32);                                        // E143
        chk("t2.timeout2", 32'(bus.o_timeout_cnt), 32'd2);
        chk("t2.repulse2", 32'(bus.o_pll_rst),     32'd1);
        cyc(36);                                        // E179
        chk("t2.timeout3", 32'(bus.o_timeout_cnt), 32'd3);
        cyc(36 * 300);
        chk_out("t2.saturate", 0, 1, 0, 2, 255);

        // Test 6a: async reset mid-PLL_RST
        cyc(1);
        chk("t6.mid_pll_rst", 32'(bus.o_state), 32'd0);
        #3 nrst = 1'b0;
        #1 chk_out("t6.async_pll_rst", 0, 1, 0, 0, 0);

        // Test 6b: async reset mid-STABLE
        bus.i_locked = 1'b1;
        cyc(1);
        nrst = 1'b1;
        cyc(4);                                         // E4
        chk("t6.wait", 32'(bus.o_state), 32'd1);
        cyc(1);                                         // E5
        chk("t6.stable", 32'(bus.o_state), 32'd2);
        cyc(3);                                         // E8
        #3 nrst = 1'b0;
        #1 chk_out("t6.async_stable", 0, 1, 0, 0, 0);

        // Lock loss coinciding with soft reset, then async reset in RUN
        cyc(1);
        nrst = 1'b1;
        cyc(13);                                        // E13
        chk_out("t6.run_again", 3, 0, 1, 0, 0);
        bus.i_locked = 1'b0;
        cyc(2);                                         // E15
        bus.i_soft_rst = 1'b1;
        cyc(1);                                         // E16
        bus.i_soft_rst = 1'b0;
        bus.i_locked   = 1'b1;
        chk_out("t5.soft_vs_loss", 0, 1, 0, 0, 0);
        cyc(13);                                        // E29
        chk_out("t6.run_third", 3, 0, 1, 0, 0);
        #3 nrst = 1'b0;
        #1 chk_out("t6.async_run", 0, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
